// File: rtl/sck_frac_gen.sv
// Fractional-rate serial clock generator: a fixed-point phase accumulator places
// every SCK edge on an integer clk cycle so the average half-period equals brd.
module sck_frac_gen #(
   parameter int ACC_W  = 32,
   parameter int FRAC_W = 7,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             start,
   input  logic [ACC_W-1:0] brd,
   input  logic [CNT_W-1:0] nbits,
   input  logic             cpol,
   output logic             sck,
   output logic             lead_stb,
   output logic             trail_stb,
   output logic             busy,
   output logic             done,
   output logic             err
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [ACC_W-1:0] ACC_STEP = {{(ACC_W-1){1'b0}}, 1'b1} << FRAC_W;
   localparam logic [CNT_W:0]   CNT_ONE  = {{CNT_W{1'b0}}, 1'b1};

   state_t           r_state;
   state_t           w_next;
   logic [ACC_W-1:0] r_acc;
   logic [ACC_W-1:0] r_match;
   logic [ACC_W-1:0] r_brd;
   logic [CNT_W:0]   r_cnt;
   logic [CNT_W:0]   r_last;
   logic             r_cpol;
   logic             w_accept;
   logic             w_reject;
   logic             w_hit;

   // Only the integer parts are compared, so both accumulators may wrap freely
   // and edges always land on whole clk cycles.
   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_reject = 1'b0;
      w_hit    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start && enable) begin
               if ((|brd[ACC_W-1:FRAC_W]) && (|nbits)) begin
                  w_accept = 1'b1;
                  w_next   = S_RUN;
               end else begin
                  w_reject = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (!enable) begin
               w_next = S_IDLE;
            end else if (r_acc[ACC_W-1:FRAC_W] == r_match[ACC_W-1:FRAC_W]) begin
               w_hit = 1'b1;
               if ((r_cnt + CNT_ONE) == r_last) begin
                  w_next = S_DONE;
               end
            end
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // busy and done mirror the state one cycle late; dropping enable kills both at once.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_acc     <= '0;
         r_match   <= '0;
         r_brd     <= '0;
         r_cnt     <= '0;
         r_last    <= '0;
         r_cpol    <= 1'b0;
         sck       <= 1'b0;
         lead_stb  <= 1'b0;
         trail_stb <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         r_state   <= w_next;
         busy      <= (r_state == S_RUN) && enable;
         done      <= (r_state == S_DONE) && enable;
         err       <= w_reject;
         lead_stb  <= w_hit && !r_cnt[0];
         trail_stb <= w_hit && r_cnt[0];
         case (r_state)
            S_IDLE: begin
               sck <= cpol;
               if (w_accept) begin
                  r_acc   <= ACC_STEP;
                  r_match <= brd;
                  r_brd   <= brd;
                  r_cnt   <= '0;
                  r_last  <= {nbits, 1'b0};
                  r_cpol  <= cpol;
               end
            end
            S_RUN: begin
               if (!enable) begin
                  sck <= r_cpol;
               end else begin
                  r_acc <= r_acc + ACC_STEP;
                  if (w_hit) begin
                     sck     <= ~sck;
                     r_match <= r_match + r_brd;
                     r_cnt   <= r_cnt + CNT_ONE;
                  end
               end
            end
            S_DONE: begin
               if (!enable) begin
                  sck <= r_cpol;
               end
            end
            default: sck <= r_cpol;
         endcase
      end
   end

endmodule

// File: tb/tb_sck_frac_gen.sv
// Self-checking bench for sck_frac_gen: a 32-bit instance and a narrow 12-bit
// instance (whose accumulators wrap every 32 cycles) run side by side on the same stimulus.
module tb_sck_frac_gen;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        start;
   logic        cpol;
   logic [31:0] brd;
   logic [7:0]  nbits;

   logic sckM, leadM, trailM, busyM, doneM, errM;
   logic sckW, leadW, trailW, busyW, doneW, errW;
   logic [5:0] vecM;
   logic [5:0] vecW;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sck_frac_gen u_main (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .start     (start),
      .brd       (brd),
      .nbits     (nbits),
      .cpol      (cpol),
      .sck       (sckM),
      .lead_stb  (leadM),
      .trail_stb (trailM),
      .busy      (busyM),
      .done      (doneM),
      .err       (errM)
   );

   sck_frac_gen #(.ACC_W(12), .FRAC_W(7), .CNT_W(8)) u_wrap (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .start     (start),
      .brd       (brd[11:0]),
      .nbits     (nbits),
      .cpol      (cpol),
      .sck       (sckW),
      .lead_stb  (leadW),
      .trail_stb (trailW),
      .busy      (busyW),
      .done      (doneW),
      .err       (errW)
   );

   assign vecM = {sckM, leadM, trailM, busyM, doneM, errM};
   assign vecW = {sckW, leadW, trailW, busyW, doneW, errW};

   // Reference: SCK edge k of a transfer lands floor(k*brd) cycles after the
   // start edge; busy covers cycles 1..last edge, done follows one cycle later.
   task automatic run_xfer(input string name, input logic [31:0] b, input int n,
                           input logic cp, input int abortAfter, input bit noise);
      longint     t[];
      longint     last;
      longint     abortEdge;
      longint     endE;
      longint     noiseLimit;
      logic [5:0] exp;
      int         c;
      logic       ld;
      logic       tr;
      t = new[2*n+1];
      for (int k = 1; k <= 2*n; k++) t[k] = (longint'(k) * longint'(b)) >>> 7;
      last       = t[2*n];
      abortEdge  = (abortAfter > 0) ? t[abortAfter] + 1 : -1;
      endE       = (abortAfter > 0) ? abortEdge + 2 : last + 2;
      noiseLimit = (abortAfter > 0) ? abortEdge - 1 : last;
      brd = b; nbits = n[7:0]; cpol = cp; enable = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      exp = {cp, 5'b0};
      checks++;
      if (vecM !== exp) begin
         errors++;
         $display("[TB] FAIL %s main edge 0 got %b want %b", name, vecM, exp);
      end
      checks++;
      if (vecW !== exp) begin
         errors++;
         $display("[TB] FAIL %s wrap edge 0 got %b want %b", name, vecW, exp);
      end
      start = 1'b0;
      for (longint e = 1; e <= endE; e++) begin
         if (noise && e <= noiseLimit) begin
            start = 1'($urandom_range(0, 1));
            brd   = 32'($urandom_range(0, 4095));
            nbits = 8'($urandom_range(0, 255));
            cpol  = 1'($urandom_range(0, 1));
         end else begin
            start = 1'b0;
            cpol  = cp;
         end
         if (abortAfter > 0 && e == abortEdge) enable = 1'b0;
         @(posedge clk); #1;
         if (abortAfter > 0 && e >= abortEdge) begin
            exp = {cp, 5'b0};
         end else begin
            c = 0; ld = 1'b0; tr = 1'b0;
            for (int k = 1; k <= 2*n; k++) begin
               if (t[k] <= e) c++;
               if (t[k] == e) begin
                  if (k % 2 == 1) ld = 1'b1;
                  else            tr = 1'b1;
               end
            end
            exp = {cp ^ c[0], ld, tr, (e <= last), (e == last + 1), 1'b0};
         end
         checks++;
         if (vecM !== exp) begin
            errors++;
            $display("[TB] FAIL %s main edge %0d got %b want %b", name, e, vecM, exp);
         end
         checks++;
         if (vecW !== exp) begin
            errors++;
            $display("[TB] FAIL %s wrap edge %0d got %b want %b", name, e, vecW, exp);
         end
      end
      enable = 1'b1; start = 1'b0; cpol = cp;
   endtask

   task automatic test_reset();
      logic [5:0] exp;
      reset = 1'b1; enable = 1'b1; start = 1'b1; brd = 32'h200; nbits = 8'd2; cpol = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i == 2) begin reset = 1'b0; start = 1'b0; end
         if (i == 3) cpol = 1'b0;
         @(posedge clk); #1;
         exp = (i == 2) ? 6'b100000 : 6'b000000;
         checks++;
         if (vecM !== exp) begin
            errors++;
            $display("[TB] FAIL reset main step %0d got %b want %b", i, vecM, exp);
         end
         checks++;
         if (vecW !== exp) begin
            errors++;
            $display("[TB] FAIL reset wrap step %0d got %b want %b", i, vecW, exp);
         end
      end
   endtask

   task automatic test_integer();
      run_xfer("integer_4p0", 32'h200, 2, 1'b0, -1, 1'b0);
   endtask

   task automatic test_fraction();
      run_xfer("fraction_2p5", 32'h140, 4, 1'b1, -1, 1'b0);
   endtask

   task automatic test_reject();
      logic [31:0] tBrd[8]   = '{32'h40, 32'h40, 32'h200, 32'h200, 32'h200, 32'h200, 32'h7F, 32'h7F};
      logic [7:0]  tNbits[8] = '{8'd3, 8'd3, 8'd0, 8'd0, 8'd2, 8'd2, 8'd3, 8'd3};
      logic        tEn[8]    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      logic        tStart[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [5:0]  tExp[8]   = '{6'b000001, 6'b0, 6'b000001, 6'b0, 6'b0, 6'b0, 6'b000001, 6'b0};
      cpol = 1'b0;
      for (int i = 0; i < 8; i++) begin
         brd = tBrd[i]; nbits = tNbits[i]; enable = tEn[i]; start = tStart[i];
         @(posedge clk); #1;
         checks++;
         if (vecM !== tExp[i]) begin
            errors++;
            $display("[TB] FAIL reject main row %0d got %b want %b", i, vecM, tExp[i]);
         end
         checks++;
         if (vecW !== tExp[i]) begin
            errors++;
            $display("[TB] FAIL reject wrap row %0d got %b want %b", i, vecW, tExp[i]);
         end
      end
      start = 1'b0; enable = 1'b1;
   endtask

   task automatic test_abort();
      run_xfer("abort_edge3", 32'h180, 8, 1'b1, 3, 1'b0);
      run_xfer("restart", 32'h180, 8, 1'b1, -1, 1'b0);
   endtask

   task automatic test_wrap();
      run_xfer("wrap_31p5", 32'hFC0, 6, 1'b0, -1, 1'b0);
      run_xfer("wrap_31p0", 32'hF80, 3, 1'b1, -1, 1'b1);
      run_xfer("wrap_3p5", 32'h1C0, 20, 1'b0, -1, 1'b1);
   endtask

   task automatic test_reset_mid();
      logic [5:0] exp;
      brd = 32'h180; nbits = 8'd5; cpol = 1'b0; enable = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      for (int e = 1; e <= 5; e++) begin
         start = (e == 5);
         @(posedge clk); #1;
      end
      // one toggle at edge 3, start at edge 5 ignored while running
      exp = 6'b100100;
      checks++;
      if (vecM !== exp) begin
         errors++;
         $display("[TB] FAIL busy_start main got %b want %b", vecM, exp);
      end
      checks++;
      if (vecW !== exp) begin
         errors++;
         $display("[TB] FAIL busy_start wrap got %b want %b", vecW, exp);
      end
      reset = 1'b1; start = 1'b1; cpol = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; start = 1'b0; cpol = 1'b0;
      for (int i = 0; i < 21; i++) begin
         checks++;
         if (vecM !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid main step %0d got %b want %b", i, vecM, 6'b0);
         end
         checks++;
         if (vecW !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid wrap step %0d got %b want %b", i, vecW, 6'b0);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_random();
      logic [31:0] b;
      int          n;
      logic        cp;
      for (int i = 0; i < 6; i++) begin
         b  = 32'($urandom_range(32'h80, 32'h37F));
         n  = int'($urandom_range(1, 6));
         cp = 1'($urandom_range(0, 1));
         run_xfer($sformatf("random_%0d", i), b, n, cp, -1, 1'b1);
      end
   endtask

   initial begin
      test_reset();
      test_integer();
      test_fraction();
      test_reject();
      test_abort();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sck_frac_gen.md
SCK_FRAC_GEN -- requirements
Module: sck_frac_gen

Interface
REQ-001 SHALL have parameter ACC_W, default 32, meaning accumulator/divisor width in bits.
REQ-002 SHALL have parameter FRAC_W, default 7, meaning fractional bits of brd (ACC_W-FRAC_W integer bits).
REQ-003 SHALL have parameter CNT_W, default 8, meaning width of nbits and the internal edge counter (counter is CNT_W+1 bits).
REQ-004 SHALL have ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  level; low aborts any transfer.
- start  in  1  one-cycle request pulse.
- brd  in  ACC_W  SCK half-period in clk cycles, unsigned fixed-point with FRAC_W fractional bits.
- nbits  in  CNT_W  number of SCK cycles per transfer.
- cpol  in  1  SCK idle level.
- sck  out  1  generated serial clock.
- lead_stb  out  1  one-cycle pulse on every leading (odd-numbered) SCK edge.
- trail_stb  out  1  one-cycle pulse on every trailing (even-numbered) SCK edge.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse on normal completion.
- err  out  1  one-cycle pulse on rejected start.

Function
REQ-005 SHALL implement states IDLE, RUN, DONE; all outputs registered.
REQ-006 In IDLE, start=1 with enable=1, brd[ACC_W-1:FRAC_W]!=0 and nbits!=0 SHALL latch brd, nbits, cpol, set acc=1<<FRAC_W, match=brd, edge count=0, and enter RUN (busy=1 next cycle).
REQ-007 In IDLE, start=1 with enable=1 and (brd integer part==0 or nbits==0) SHALL pulse err for one cycle and remain in IDLE.
REQ-008 start in RUN or DONE, or with enable=0, SHALL be ignored (no err).
REQ-009 In RUN, each cycle SHALL add 1<<FRAC_W to acc, modulo 2^ACC_W.
REQ-010 In RUN, when acc[ACC_W-1:FRAC_W]==match[ACC_W-1:FRAC_W], the next edge SHALL toggle sck, set match=match+brd (modulo 2^ACC_W), and increment edge count.
REQ-011 Toggles SHALL occur at integer clk cycles; for integer brd=N, the first toggle lands N cycles after the start edge, then every N cycles.
REQ-012 For fractional brd, the average half-period over 2^FRAC_W edges SHALL equal brd exactly, each individual half-period being floor or ceil of brd.
REQ-013 Wrap of acc and match past 2^ACC_W SHALL NOT disturb the toggle spacing.
REQ-014 lead_stb SHALL assert in the same cycle as the odd-numbered sck toggle (edge 1,3,...); trail_stb with even-numbered toggles; never both.
REQ-015 On edge number 2*nbits (sck returns to latched cpol), the FSM SHALL enter DONE; DONE lasts one cycle with done=1, busy=0, then IDLE.
REQ-016 enable=0 in RUN or DONE SHALL, on the next edge, force IDLE, sck=latched cpol, busy=0, and no done/strobe pulses.
REQ-017 In IDLE, sck SHALL follow the cpol input with one-cycle latency.
REQ-018 brd, nbits and cpol changes during RUN SHALL have no effect until the next accepted start.

Reset
REQ-019 reset=1 SHALL, on the next clk edge, force IDLE, sck=0, lead_stb=0, trail_stb=0, busy=0, done=0, err=0, acc=0, match=0, edge count=0, regardless of state.
REQ-020 reset SHALL override enable and start in the same cycle; a transfer in progress is abandoned without done.

Verification
REQ-021 brd=0x200 (4.0), nbits=2, cpol=0, start at cycle 0 -> sck toggles at cycles 4,8,12,16; lead_stb at 4,12; trail_stb at 8,16; done at 17; busy 1..16.
REQ-022 brd=0x140 (2.5), nbits=4, cpol=1 -> half-periods alternate 2,3 (8 edges, total 20 cycles); sck idle 1; done once.
REQ-023 brd=0x40 (0.5) or nbits=0 with start -> err pulse 1 cycle, busy stays 0, sck unchanged.
REQ-024 Transfer with acc/match preloaded near 2^32 (brd=0x7FFFFF80 region, long run) -> constant spacing across wrap.
REQ-025 enable dropped at edge 3 of 8 -> next cycle IDLE, sck=cpol, no done; restart accepted afterwards.
REQ-026 reset asserted mid-RUN, and start pulsed while busy -> all outputs 0 next cycle; busy-time start produces no effect.
